// File: rtl/ahb_master_arbiter.sv
// AHB-Lite multi-master arbiter: round-robin address-bus ownership handed over only
// at IDLE boundaries, with per-master gating of HREADY/HRESP.

module ahb_master_arbiter_lane #(
    parameter int IDX = 0
) (
    input  logic [1:0] i_addr_owner,
    input  logic [1:0] i_data_owner,
    input  logic       i_data_active,
    input  logic       i_hready,
    input  logic       i_hresp,
    output logic       o_grant,
    output logic       o_hready,
    output logic       o_hresp
);
    logic w_is_addr;
    logic w_is_data;

    assign w_is_addr = (i_addr_owner == 2'(IDX));
    assign w_is_data = (i_data_owner == 2'(IDX));
    assign o_grant   = w_is_addr;
    // Non-owners never see ready, which keeps their adapters from advancing.
    assign o_hready  = w_is_addr & i_hready;
    assign o_hresp   = w_is_data & i_data_active & i_hresp;
endmodule

module ahb_master_arbiter #(
    parameter int NUM_M     = 2,
    parameter int DEFAULT_M = 0
) (
    input  logic                        hclk_i,
    input  logic                        hresetn_i,
    input  logic [NUM_M-1:0]            m_hbusreq_i,
    input  logic [NUM_M-1:0][1:0]       m_htrans_i,
    input  logic [NUM_M-1:0][31:0]      m_haddr_i,
    input  logic [NUM_M-1:0]            m_hwrite_i,
    input  logic [NUM_M-1:0][2:0]       m_hsize_i,
    input  logic [NUM_M-1:0][3:0]       m_hprot_i,
    input  logic [NUM_M-1:0][2:0]       m_hburst_i,
    input  logic [NUM_M-1:0][31:0]      m_hwdata_i,
    output logic [NUM_M-1:0]            m_hgrant_o,
    output logic [NUM_M-1:0]            m_hready_o,
    output logic [NUM_M-1:0]            m_hresp_o,
    output logic [31:0]                 m_hrdata_o,
    output logic [31:0]                 haddr_o,
    output logic                        hwrite_o,
    output logic [2:0]                  hsize_o,
    output logic [3:0]                  hprot_o,
    output logic [2:0]                  hburst_o,
    output logic [1:0]                  htrans_o,
    output logic [31:0]                 hwdata_o,
    output logic                        hmastlock_o,
    output logic [1:0]                  hmaster_o,
    input  logic [31:0]                 hrdata_i,
    input  logic                        hready_i,
    input  logic                        hresp_i
);
    logic [1:0] r_addr_owner;
    logic [1:0] r_data_owner;
    logic       r_data_active;
    logic [1:0] w_next_owner;
    logic [3:0] w_req;

    assign w_req       = 4'(m_hbusreq_i);
    assign m_hrdata_o  = hrdata_i;
    assign hmastlock_o = 1'b0;
    assign hmaster_o   = r_addr_owner;

    genvar g;
    generate
        for (g = 0; g < NUM_M; g++) begin : g_lane
            ahb_master_arbiter_lane #(.IDX(g)) u_lane (
                .i_addr_owner (r_addr_owner),
                .i_data_owner (r_data_owner),
                .i_data_active(r_data_active),
                .i_hready     (hready_i),
                .i_hresp      (hresp_i),
                .o_grant      (m_hgrant_o[g]),
                .o_hready     (m_hready_o[g]),
                .o_hresp      (m_hresp_o[g])
            );
        end
    endgenerate

    always_comb begin
        haddr_o  = '0;
        hwrite_o = 1'b0;
        hsize_o  = '0;
        hprot_o  = '0;
        hburst_o = '0;
        htrans_o = '0;
        hwdata_o = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (r_addr_owner == 2'(i)) begin
                haddr_o  = m_haddr_i[i];
                hwrite_o = m_hwrite_i[i];
                hsize_o  = m_hsize_i[i];
                hprot_o  = m_hprot_i[i];
                hburst_o = m_hburst_i[i];
                htrans_o = m_htrans_i[i];
            end
            if (r_data_owner == 2'(i))
                hwdata_o = m_hwdata_i[i];
        end
    end

    // Search owner+1 .. owner (mod NUM_M); the current owner is checked last.
    always_comb begin
        logic       found;
        logic [1:0] cand;
        w_next_owner = r_addr_owner;
        found        = 1'b0;
        cand         = r_addr_owner;
        for (int k = 1; k <= NUM_M; k++) begin
            cand = 2'((int'(r_addr_owner) + k) % NUM_M);
            if (!found && w_req[cand]) begin
                w_next_owner = cand;
                found        = 1'b1;
            end
        end
    end

    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            r_addr_owner  <= 2'(DEFAULT_M);
            r_data_owner  <= 2'(DEFAULT_M);
            r_data_active <= 1'b0;
        end else if (hready_i) begin
            r_data_owner  <= r_addr_owner;
            r_data_active <= htrans_o[1];
            if (htrans_o == 2'b00)
                r_addr_owner <= w_next_owner;
        end
    end
endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001: Parameter NUM_M, default 2, number of AHB-Lite masters; legal range 2..4.
REQ-002: Parameter DEFAULT_M, default 0, master index parked on at reset; must be less than NUM_M.
REQ-003: The block SHALL use one clock and one reset: asynchronous, active-low.
REQ-004: Ports:
- hclk_i  in  1  AHB clock.
- hresetn_i  in  1  asynchronous active-low reset.
- m_hbusreq_i  in  NUM_M  per-master bus request.
- m_htrans_i  in  2*NUM_M  per-master HTRANS.
- m_haddr_i  in  32*NUM_M  per-master HADDR.
- m_hwrite_i  in  NUM_M  per-master HWRITE.
- m_hsize_i  in  3*NUM_M  per-master HSIZE.
- m_hprot_i  in  4*NUM_M  per-master HPROT.
- m_hburst_i  in  3*NUM_M  per-master HBURST.
- m_hwdata_i  in  32*NUM_M  per-master HWDATA.
- m_hgrant_o  out  NUM_M  one-hot address-bus ownership.
- m_hready_o  out  NUM_M  per-master gated HREADY.
- m_hresp_o  out  NUM_M  per-master gated HRESP.
- m_hrdata_o  out  32  HRDATA, broadcast to all masters.
- haddr_o, hwrite_o, hsize_o, hprot_o, hburst_o, htrans_o  out  32/1/3/4/3/2  muxed slave-side address/control.
- hwdata_o  out  32  muxed write data.
- hmastlock_o  out  1  tied low.
- hmaster_o  out  2  current address owner index.
- hrdata_i, hready_i, hresp_i  in  32/1/1  slave-side response.

Function
REQ-005: State registers SHALL be limited to: addr_owner (2 bits), data_owner (2 bits) and data_active (1 bit).
REQ-006: m_hgrant_o SHALL equal the one-hot decode of addr_owner, and hmaster_o SHALL equal addr_owner.
REQ-007: haddr_o, hwrite_o, hsize_o, hprot_o, hburst_o and htrans_o SHALL be combinationally selected from master addr_owner.
REQ-008: hwdata_o SHALL be selected from master data_owner.
REQ-009: m_hrdata_o SHALL equal hrdata_i.
REQ-010: m_hready_o[i] SHALL equal hready_i when i equals addr_owner, and 0 otherwise.
- A non-owner therefore never observes a ready cycle, so its adapter never grants.
REQ-011: m_hresp_o[i] SHALL equal hresp_i when data_active is 1 and i equals data_owner, and 0 otherwise.
REQ-012: On each cycle with hready_i=1, data_owner SHALL load addr_owner.
REQ-013: On each cycle with hready_i=1, data_active SHALL load (htrans_o[1]==1).
REQ-014: When hready_i=0, data_owner and data_active SHALL hold.
REQ-015: Re-arbitration SHALL occur only in a cycle where hready_i=1 and the owner's htrans is IDLE (2'b00).
- In any other cycle, addr_owner holds.
REQ-016: At a re-arbitration point, addr_owner SHALL load the first master with m_hbusreq_i=1, searching round-robin from addr_owner+1 (mod NUM_M) and checking the current owner last.
REQ-017: If no master requests at a re-arbitration point, addr_owner SHALL hold (parking).
REQ-018: Grant latency SHALL be one cycle: a request sampled at a re-arbitration point yields m_hgrant_o on the following cycle.
REQ-019: After a handover, the previous owner's final transfer completes in the handover cycle, so at most one data phase is ever outstanding.
REQ-020: An owner issuing back-to-back NONSEQ transfers retains the bus; fairness relies on masters returning to IDLE.
REQ-021: Simultaneous requests at a re-arbitration point SHALL resolve in round-robin order only; there is no fixed priority.
REQ-022: Out-of-range indices (NUM_M<4) SHALL never be selected.
REQ-023: hmastlock_o SHALL be 0.

Reset
REQ-024: While hresetn_i=0, the block SHALL force addr_owner=DEFAULT_M, data_owner=DEFAULT_M and data_active=0, regardless of clock.
REQ-025: Consequently, during reset m_hgrant_o=1<<DEFAULT_M, hmaster_o=DEFAULT_M and m_hresp_o=0.
REQ-026: Reset asserted mid-transfer SHALL abandon the transfer with no recovery.
REQ-027: On the first clock after deassertion, the block SHALL arbitrate normally.

Verification
REQ-028: Reset with NUM_M=2, DEFAULT_M=0 -> m_hgrant_o=2'b01, hmaster_o=0, m_hready_o=2'b01 while hready_i=1.
REQ-029: Master1 requests; master0 IDLE; hready_i=1 -> next cycle m_hgrant_o=2'b10; m_hready_o[0]=0; master1 NONSEQ to 0x1000 appears on haddr_o.
REQ-030: Both request every cycle, both alternating NONSEQ/IDLE, zero-wait slave -> ownership alternates 0,1,0,1 at each IDLE; no transfer lost or duplicated.
REQ-031: Owner1 writes 0xDEADBEEF with hready_i held low 3 cycles, master0 requesting -> hwdata_o stays 0xDEADBEEF, addr_owner holds through the stall, handover follows the first IDLE with hready_i=1.
REQ-032: Owner0 read gets hresp_i=1 -> m_hresp_o=2'b01 for exactly the response cycles; m_hresp_o[1]=0.
REQ-033: Reset asserted while master1 owns mid-data-phase -> immediately m_hgrant_o=2'b01, m_hresp_o=0; post-reset, master1's request is granted one cycle after master0 is IDLE.
